// File: rtl/run_result_checker.sv
// End-of-run result checker: runs the core for a bounded time, then reads back each
// expected-value table entry through the debug read port and records pass/fail.
module run_result_checker #(
   parameter int XLEN       = 32,
   parameter int NUM_CHECKS = 16,
   parameter int ADDR_W     = 10,
   parameter int RUN_CYCLES = 20,
   parameter int CNT_W      = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cfg_we,
   input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
   input  logic                          cfg_kind,
   input  logic [ADDR_W-1:0]             cfg_addr,
   input  logic [XLEN-1:0]               cfg_data,
   input  logic                          start,
   input  logic                          halt,
   output logic                          dbg_re,
   output logic                          dbg_kind,
   output logic [ADDR_W-1:0]             dbg_addr,
   input  logic [XLEN-1:0]               dbg_rdata,
   output logic                          core_reset,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic [CNT_W-1:0]              fail_count,
   output logic [$clog2(NUM_CHECKS)-1:0] first_fail_idx,
   output logic [XLEN-1:0]               first_fail_actual,
   output logic [CNT_W-1:0]              cycle_count,
   output logic [2:0]                    fsm_state
);

   localparam int PTR_W = $clog2(NUM_CHECKS);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_CHECKS - 1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_REQ, S_RSP, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [NUM_CHECKS-1:0] r_valid;
   logic              r_kind [NUM_CHECKS];
   logic [ADDR_W-1:0] r_addr [NUM_CHECKS];
   logic [XLEN-1:0]   r_data [NUM_CHECKS];
   logic [PTR_W-1:0]  r_ptr;
   logic [31:0]       r_run_cnt;
   logic [CNT_W-1:0]  r_cycle_count;
   logic [CNT_W-1:0]  r_fail_count;
   logic [PTR_W-1:0]  r_ff_idx;
   logic [XLEN-1:0]   r_ff_actual;

   logic w_cfg_wr;
   logic w_start;
   logic w_run_end;
   logic w_entry_valid;
   logic w_mismatch;

   assign w_cfg_wr      = cfg_we && (r_state == S_IDLE);
   assign w_start       = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_run_end     = halt || (r_run_cnt == 32'(RUN_CYCLES - 1));
   assign w_entry_valid = r_valid[r_ptr];
   assign w_mismatch    = (dbg_rdata != r_data[r_ptr]);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid <= '0;
      end else if (w_cfg_wr) begin
         r_valid[cfg_idx] <= 1'b1;
      end
   end

   // Payload needs no reset: an entry is only ever read while its valid bit is set.
   always_ff @(posedge clock) begin
      if (!reset && w_cfg_wr) begin
         r_kind[cfg_idx] <= cfg_kind;
         r_addr[cfg_idx] <= cfg_addr;
         r_data[cfg_idx] <= cfg_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_next = S_RUN;
         S_RUN:  if (w_run_end) w_next = S_REQ;
         S_REQ: begin
            if (w_entry_valid)      w_next = S_RSP;
            else if (r_ptr == LAST) w_next = S_DONE;
         end
         S_RSP:  w_next = (r_ptr == LAST) ? S_DONE : S_REQ;
         S_DONE: if (w_start) w_next = S_RUN;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr         <= '0;
         r_run_cnt     <= '0;
         r_cycle_count <= '0;
         r_fail_count  <= '0;
         r_ff_idx      <= '0;
         r_ff_actual   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  r_ptr         <= '0;
                  r_run_cnt     <= '0;
                  r_cycle_count <= '0;
                  r_fail_count  <= '0;
                  r_ff_idx      <= '0;
                  r_ff_actual   <= '0;
               end
            end
            S_RUN: begin
               r_run_cnt <= r_run_cnt + 32'd1;
               r_ptr     <= '0;
               if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
            end
            S_REQ: begin
               if (!w_entry_valid && (r_ptr != LAST)) r_ptr <= r_ptr + 1'b1;
            end
            S_RSP: begin
               // A saturating count never returns to zero, so zero marks "no failure yet".
               if (w_mismatch) begin
                  if (r_fail_count != '1) r_fail_count <= r_fail_count + 1'b1;
                  if (r_fail_count == '0) begin
                     r_ff_idx    <= r_ptr;
                     r_ff_actual <= dbg_rdata;
                  end
               end
               if (r_ptr != LAST) r_ptr <= r_ptr + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign dbg_re            = (r_state == S_REQ) && w_entry_valid;
   assign dbg_kind          = dbg_re ? r_kind[r_ptr] : 1'b0;
   assign dbg_addr          = dbg_re ? r_addr[r_ptr] : '0;
   assign core_reset        = (r_state != S_RUN);
   assign busy              = (r_state == S_RUN) || (r_state == S_REQ) || (r_state == S_RSP);
   assign done              = (r_state == S_DONE);
   assign pass              = done && (r_fail_count == '0);
   assign fail_count        = r_fail_count;
   assign first_fail_idx    = r_ff_idx;
   assign first_fail_actual = r_ff_actual;
   assign cycle_count       = r_cycle_count;
   assign fsm_state         = r_state;

endmodule
